// File: rtl/ba_register_file_pkg.sv
// ---------------------------------------------------------------------------
// ba_register_file_pkg
//   Shared CPU constants used by the general-purpose register file and its
//   read ports: default data width, register count, the matching address
//   width, and the register address / data typedefs.
// ---------------------------------------------------------------------------
package ba_register_file_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int REG_COUNT      = 16;
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/ba_read_port.sv
// ---------------------------------------------------------------------------
// ba_read_port
//   One combinational read port of the register file.
//   It selects a register and its busy bit, and applies the BAout zero mask
//   to register 0. When REGFILE_BYPASS_EN is defined, the port forwards a
//   same-cycle write to the selected register (write-first).
//
// Optional feature macro: REGFILE_BYPASS_EN
//
// Ports
//   regs      in   storage array from the top module
//   busy      in   registered scoreboard, bit i = register i busy
//   rd_addr   in   register index
//   ba_out    in   BAout qualifier; register 0 reads as zero while set
//   wr_en     in   write port enable (bypass use only)
//   wr_addr   in   write port index (bypass use only)
//   wr_data   in   write port data (bypass use only)
//   rsv_en    in   reserve enable (bypass use only)
//   rsv_addr  in   reserve index (bypass use only)
//   rd_data   out  selected (possibly masked or forwarded) data
//   rd_busy   out  busy bit of the selected register
// ---------------------------------------------------------------------------
module ba_read_port
  import ba_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int NUM_REGS   = REG_COUNT,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0]   busy,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  ba_out,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_busy
);

  // The zero mask is applied last so that it overrides a forwarded write
  // to register 0.
  always_comb begin
    rd_data = regs[rd_addr];
    rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
      // A same-cycle reserve of the register being written wins over the
      // release, so the busy bit is only cleared early without one.
      if (!(rsv_en && (rsv_addr == wr_addr))) begin
        rd_busy = 1'b0;
      end
    end
`endif
    if (ba_out && (rd_addr == '0)) begin
      rd_data = '0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  // Without forwarding, the write and reserve inputs have no function here.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data, rsv_en, rsv_addr};
`endif

endmodule

// File: rtl/ba_register_file.sv
// ---------------------------------------------------------------------------
// ba_register_file
//   General-purpose register file with one synchronous write port, two
//   combinational read ports (A, B), each with a BAout qualifier, and a
//   per-register busy scoreboard used for RAW hazard detection.
//
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding on the
//   read ports; see ba_read_port)
//
// Ports
//   clock      in   rising-edge clock
//   clear      in   asynchronous active-high reset
//   wr_en      in   write enable
//   wr_addr    in   write register index
//   wr_data    in   write data
//   rsv_en     in   reserve enable (mark destination busy)
//   rsv_addr   in   register to reserve
//   rd_addr_a  in   port A index
//   ba_out_a   in   port A BAout qualifier
//   rd_data_a  out  port A data
//   rd_busy_a  out  port A busy bit
//   rd_addr_b  in   port B index
//   ba_out_b   in   port B BAout qualifier
//   rd_data_b  out  port B data
//   rd_busy_b  out  port B busy bit
//   busy_vec   out  full scoreboard
// ---------------------------------------------------------------------------
module ba_register_file
  import ba_register_file_pkg::*;
#(
  parameter int          DATA_WIDTH = REG_DATA_WIDTH,
  parameter int          NUM_REGS   = REG_COUNT,
  parameter int          ADDR_WIDTH = $clog2(NUM_REGS),
  parameter logic [31:0] INIT       = 32'h0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic                  ba_out_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_busy_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic                  ba_out_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_busy_b,
  output logic [NUM_REGS-1:0]   busy_vec
);

  localparam logic [DATA_WIDTH-1:0] INIT_VAL = DATA_WIDTH'(INIT);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;

  // Register storage. Register 0 is an ordinary register; only the read
  // ports treat it specially under BAout.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= INIT_VAL;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard. The reserve assignment comes after the release so that a
  // reserve and a write-back of the same register leave it busy: the new
  // producer replaces the old one.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      busy <= '0;
    end else begin
      if (wr_en) begin
        busy[wr_addr] <= 1'b0;
      end
      if (rsv_en) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  assign busy_vec = busy;

  ba_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_a (
    .regs     (regs),
    .busy     (busy),
    .rd_addr  (rd_addr_a),
    .ba_out   (ba_out_a),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_data  (rd_data_a),
    .rd_busy  (rd_busy_a)
  );

  ba_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_b (
    .regs     (regs),
    .busy     (busy),
    .rd_addr  (rd_addr_b),
    .ba_out   (ba_out_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_data  (rd_data_b),
    .rd_busy  (rd_busy_b)
  );

endmodule

// File: tb/tb_ba_register_file.sv
// ---------------------------------------------------------------------------
// tb_ba_register_file
//   Directed bench for ba_register_file: a default-size instance and a
//   32 x 16-bit instance, both sharing clock and clear.
// ---------------------------------------------------------------------------
module tb_ba_register_file;

  localparam logic [31:0] INIT_MAIN  = 32'h0000_CAFE;
  localparam logic [31:0] INIT_SMALL = 32'h1234_5678;

  logic clock = 1'b0;
  logic clear;

  // main instance: 16 x 32
  logic        wr_en, rsv_en, ba_out_a, ba_out_b, rd_busy_a, rd_busy_b;
  logic [3:0]  wr_addr, rsv_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data, rd_data_a, rd_data_b;
  logic [15:0] busy_vec;

  // sweep instance: 32 x 16
  logic        s_wr_en, s_rsv_en, s_ba_out_a, s_ba_out_b, s_rd_busy_a, s_rd_busy_b;
  logic [4:0]  s_wr_addr, s_rsv_addr, s_rd_addr_a, s_rd_addr_b;
  logic [15:0] s_wr_data, s_rd_data_a, s_rd_data_b;
  logic [31:0] s_busy_vec;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ba_register_file #(.INIT(INIT_MAIN)) u_dut (
    .clock(clock), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_addr_a(rd_addr_a), .ba_out_a(ba_out_a), .rd_data_a(rd_data_a), .rd_busy_a(rd_busy_a),
    .rd_addr_b(rd_addr_b), .ba_out_b(ba_out_b), .rd_data_b(rd_data_b), .rd_busy_b(rd_busy_b),
    .busy_vec(busy_vec)
  );

  ba_register_file #(.DATA_WIDTH(16), .NUM_REGS(32), .INIT(INIT_SMALL)) u_small (
    .clock(clock), .clear(clear),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
    .rd_addr_a(s_rd_addr_a), .ba_out_a(s_ba_out_a), .rd_data_a(s_rd_data_a), .rd_busy_a(s_rd_busy_a),
    .rd_addr_b(s_rd_addr_b), .ba_out_b(s_ba_out_b), .rd_data_b(s_rd_data_b), .rd_busy_b(s_rd_busy_b),
    .busy_vec(s_busy_vec)
  );

  // Commit one write/reserve cycle on the main instance; returns #1 after
  // the edge with both enables dropped.
  task automatic cycle_main(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                            input logic re, input logic [3:0] ra);
    @(negedge clock);
    wr_en = we; wr_addr = wa; wr_data = wd; rsv_en = re; rsv_addr = ra;
    @(posedge clock);
    #1;
    wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic test_reset;
    clear = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
    rd_addr_a = 0; rd_addr_b = 0; ba_out_a = 0; ba_out_b = 0;
    s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_rsv_en = 0; s_rsv_addr = 0;
    s_rd_addr_a = 0; s_rd_addr_b = 0; s_ba_out_a = 0; s_ba_out_b = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rd_addr_a = 4'd5; rd_addr_b = 4'd0; ba_out_b = 1'b1;
    #1;
    total++; if (rd_data_a !== INIT_MAIN) begin bad++; $display("[TB] FAIL reset_init: got %h want %h", rd_data_a, INIT_MAIN); end
    total++; if (rd_data_b !== 32'h0) begin bad++; $display("[TB] FAIL reset_ba_r0: got %h want 0", rd_data_b); end
    total++; if (s_rd_data_a !== 16'h5678) begin bad++; $display("[TB] FAIL reset_small_init: got %h want 5678", s_rd_data_a); end
    clear = 1'b0;
    ba_out_b = 1'b0;

    // activity, then clear pulsed between edges
    cycle_main(1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd7);
    rd_addr_b = 4'd7;
    #1;
    total++; if (rd_data_a !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL write_r5: got %h want deadbeef", rd_data_a); end
    total++; if (busy_vec !== 16'h0080) begin bad++; $display("[TB] FAIL busy_r7: got %h want 0080", busy_vec); end
    #1 clear = 1'b1;
    #1;
    total++; if (rd_data_a !== INIT_MAIN) begin bad++; $display("[TB] FAIL async_clear_data: got %h want %h", rd_data_a, INIT_MAIN); end
    total++; if (busy_vec !== 16'h0) begin bad++; $display("[TB] FAIL async_clear_busy: got %h want 0", busy_vec); end
    total++; if (rd_busy_b !== 1'b0) begin bad++; $display("[TB] FAIL async_clear_rd_busy: got %b want 0", rd_busy_b); end
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_ba_mask;
    cycle_main(1'b1, 4'd0, 32'h0000_1234, 1'b0, 4'd0);
    rd_addr_a = 0; rd_addr_b = 0; ba_out_a = 1'b1; ba_out_b = 1'b0;
    #1;
    total++; if (rd_data_a !== 32'h0) begin bad++; $display("[TB] FAIL ba_a_r0: got %h want 0", rd_data_a); end
    total++; if (rd_data_b !== 32'h1234) begin bad++; $display("[TB] FAIL noba_b_r0: got %h want 1234", rd_data_b); end
    ba_out_a = 1'b0;
    #1;
    total++; if (rd_data_a !== 32'h1234) begin bad++; $display("[TB] FAIL ba_toggle_off: got %h want 1234", rd_data_a); end
    ba_out_a = 1'b1;
    #1;
    total++; if (rd_data_a !== 32'h0) begin bad++; $display("[TB] FAIL ba_toggle_on: got %h want 0", rd_data_a); end
    rd_addr_a = 4'd5;
    #1;
    total++; if (rd_data_a !== INIT_MAIN) begin bad++; $display("[TB] FAIL ba_nonzero_reg: got %h want %h", rd_data_a, INIT_MAIN); end
    ba_out_a = 1'b0;
  endtask

  task automatic test_scoreboard;
    cycle_main(1'b0, 4'd0, 32'h0, 1'b1, 4'd3);
    rd_addr_a = 4'd3; ba_out_a = 1'b1;
    #1;
    total++; if (busy_vec !== 16'h0008) begin bad++; $display("[TB] FAIL rsv_r3: got %h want 0008", busy_vec); end
    total++; if (rd_busy_a !== 1'b1) begin bad++; $display("[TB] FAIL rd_busy_a_r3: got %b want 1", rd_busy_a); end
    ba_out_a = 1'b0;
    cycle_main(1'b1, 4'd3, 32'h55, 1'b0, 4'd0);
    total++; if (busy_vec !== 16'h0) begin bad++; $display("[TB] FAIL release_r3: got %h want 0", busy_vec); end
    total++; if (rd_data_a !== 32'h55) begin bad++; $display("[TB] FAIL data_r3: got %h want 55", rd_data_a); end
    total++; if (rd_busy_a !== 1'b0) begin bad++; $display("[TB] FAIL rd_busy_a_r3_clr: got %b want 0", rd_busy_a); end
  endtask

  task automatic test_same_cycle;
    cycle_main(1'b1, 4'd9, 32'h77, 1'b1, 4'd9);
    rd_addr_b = 4'd9;
    #1;
    total++; if (busy_vec !== 16'h0200) begin bad++; $display("[TB] FAIL rsv_wins_r9: got %h want 0200", busy_vec); end
    total++; if (rd_data_b !== 32'h77) begin bad++; $display("[TB] FAIL data_r9: got %h want 77", rd_data_b); end
    total++; if (rd_busy_b !== 1'b1) begin bad++; $display("[TB] FAIL rd_busy_b_r9: got %b want 1", rd_busy_b); end
    cycle_main(1'b1, 4'd2, 32'h99, 1'b1, 4'd9);
    rd_addr_b = 4'd2;
    #1;
    total++; if (busy_vec !== 16'h0200) begin bad++; $display("[TB] FAIL rsv9_wr2: got %h want 0200", busy_vec); end
    total++; if (rd_data_b !== 32'h99) begin bad++; $display("[TB] FAIL data_r2: got %h want 99", rd_data_b); end
    cycle_main(1'b0, 4'd0, 32'h0, 1'b1, 4'd2);
    total++; if (busy_vec !== 16'h0204) begin bad++; $display("[TB] FAIL rsv_r2: got %h want 0204", busy_vec); end
    cycle_main(1'b1, 4'd2, 32'hAB, 1'b1, 4'd5);
    total++; if (busy_vec !== 16'h0220) begin bad++; $display("[TB] FAIL wr2_rsv5: got %h want 0220", busy_vec); end
  endtask

  task automatic test_read_during_write;
    logic [31:0] exp_same;
    cycle_main(1'b1, 4'd4, 32'h11, 1'b0, 4'd0);
    rd_addr_a = 4'd4; ba_out_a = 1'b0;
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h22;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    total++; if (rd_data_a !== exp_same) begin bad++; $display("[TB] FAIL rdw_same_cycle: got %h want %h", rd_data_a, exp_same); end
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    #1;
    total++; if (rd_data_a !== 32'h22) begin bad++; $display("[TB] FAIL rdw_next_cycle: got %h want 22", rd_data_a); end
  endtask

  task automatic test_param_sweep;
    @(negedge clock);
    s_wr_en = 1'b1; s_wr_addr = 5'd31; s_wr_data = 16'hFFFF; s_rsv_en = 1'b1; s_rsv_addr = 5'd30;
    @(posedge clock);
    #1;
    s_wr_en = 1'b0; s_rsv_en = 1'b0;
    s_rd_addr_a = 5'd31; s_rd_addr_b = 5'd0; s_ba_out_b = 1'b1;
    #1;
    total++; if (s_rd_data_a !== 16'hFFFF) begin bad++; $display("[TB] FAIL sweep_r31: got %h want ffff", s_rd_data_a); end
    total++; if (s_rd_data_b !== 16'h0) begin bad++; $display("[TB] FAIL sweep_ba_r0: got %h want 0", s_rd_data_b); end
    total++; if (s_busy_vec !== 32'h4000_0000) begin bad++; $display("[TB] FAIL sweep_busy: got %h want 40000000", s_busy_vec); end
    s_ba_out_b = 1'b0;
    #1;
    total++; if (s_rd_data_b !== 16'h5678) begin bad++; $display("[TB] FAIL sweep_r0_noba: got %h want 5678", s_rd_data_b); end
  endtask

  initial begin
    test_reset();
    test_ba_mask();
    test_scoreboard();
    test_same_cycle();
    test_read_during_write();
    test_param_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
